// File: rtl/pipeline_pkg.sv
// pipeline_pkg
//   Shared definitions for the instruction-fetch stage: next-PC select
//   encodings, default datapath widths, the NOP word and the fetch FSM
//   state type.
package pipeline_pkg;

    localparam int PC_W    = 16;
    localparam int INSTR_W = 16;

    localparam logic [15:0] NOP_INSTR = 16'h0000;

    // next-PC select encodings driven by the ID stage
    localparam logic [1:0] PCSRC_SEQ    = 2'd0;
    localparam logic [1:0] PCSRC_JUMP   = 2'd1;
    localparam logic [1:0] PCSRC_BRANCH = 2'd2;
    localparam logic [1:0] PCSRC_RET    = 2'd3;

    // BOOT spends one cycle loading a NOP into IF/ID before fetching starts
    typedef enum logic [0:0] {
        FETCH_BOOT = 1'b0,
        FETCH_RUN  = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/pc_next_mux.sv
// pc_next_mux
//   Combinational next-PC logic: the sequential incrementer plus a 4:1
//   select of the redirect target.
// Ports
//   pc            in   current PC
//   pc_src        in   target select (SEQ / JUMP / BRANCH / RET)
//   jump_target   in   absolute JMP/CALL target
//   branch_target in   precomputed branch target
//   ret_addr      in   return address
//   pc_plus1      out  pc + 1, wrapping modulo 2^PC_W
//   pc_target     out  selected redirect target
module pc_next_mux
    import pipeline_pkg::*;
#(
    parameter int PC_W = 16
) (
    input  logic [PC_W-1:0] pc,
    input  logic [1:0]      pc_src,
    input  logic [PC_W-1:0] jump_target,
    input  logic [PC_W-1:0] branch_target,
    input  logic [PC_W-1:0] ret_addr,
    output logic [PC_W-1:0] pc_plus1,
    output logic [PC_W-1:0] pc_target
);

    // carry out of the MSB is dropped, so all-ones wraps to zero
    assign pc_plus1 = pc + PC_W'(1);

    always_comb begin
        pc_target = pc_plus1;
        case (pc_src)
            PCSRC_SEQ:    pc_target = pc_plus1;
            PCSRC_JUMP:   pc_target = jump_target;
            PCSRC_BRANCH: pc_target = branch_target;
            PCSRC_RET:    pc_target = ret_addr;
            default:      pc_target = pc_plus1;
        endcase
    end

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage
//   Instruction-fetch stage and IF/ID pipeline register. Holds the PC,
//   redirects it on a kill from ID, freezes on load-use stall and counts
//   fetched and squashed slots (saturating).
// Ports
//   clk, reset                       clock, async active-high reset
//   stall, kill, pc_src              hazard / control-transfer controls
//   jump_target, branch_target,
//   ret_addr                         redirect targets from ID
//   imem_addr / imem_data            combinational instruction memory read
//   ifid_instr, ifid_pc,
//   ifid_pc_plus1, ifid_valid        IF/ID register contents
//   fetch_cnt, flush_cnt             saturating performance counters
module fetch_stage #(
    parameter int                  PC_W      = pipeline_pkg::PC_W,
    parameter int                  INSTR_W   = pipeline_pkg::INSTR_W,
    parameter logic [PC_W-1:0]     RESET_PC  = '0,
    parameter logic [INSTR_W-1:0]  NOP_INSTR = pipeline_pkg::NOP_INSTR,
    parameter int                  CNT_W     = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               stall,
    input  logic               kill,
    input  logic [1:0]         pc_src,
    input  logic [PC_W-1:0]    jump_target,
    input  logic [PC_W-1:0]    branch_target,
    input  logic [PC_W-1:0]    ret_addr,
    output logic [PC_W-1:0]    imem_addr,
    input  logic [INSTR_W-1:0] imem_data,
    output logic [INSTR_W-1:0] ifid_instr,
    output logic [PC_W-1:0]    ifid_pc,
    output logic [PC_W-1:0]    ifid_pc_plus1,
    output logic               ifid_valid,
    output logic [CNT_W-1:0]   fetch_cnt,
    output logic [CNT_W-1:0]   flush_cnt
);
    import pipeline_pkg::*;

    fetch_state_t       state_reg;
    logic [PC_W-1:0]    pc_reg;
    logic [PC_W-1:0]    pc_plus1;
    logic [PC_W-1:0]    pc_target;
    logic [INSTR_W-1:0] ifid_instr_reg;
    logic [PC_W-1:0]    ifid_pc_reg;
    logic [PC_W-1:0]    ifid_pc_plus1_reg;
    logic               ifid_valid_reg;
    logic [CNT_W-1:0]   fetch_cnt_reg;
    logic [CNT_W-1:0]   flush_cnt_reg;

    pc_next_mux #(
        .PC_W(PC_W)
    ) u_pc_next_mux (
        .pc            (pc_reg),
        .pc_src        (pc_src),
        .jump_target   (jump_target),
        .branch_target (branch_target),
        .ret_addr      (ret_addr),
        .pc_plus1      (pc_plus1),
        .pc_target     (pc_target)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg         <= FETCH_BOOT;
            pc_reg            <= RESET_PC;
            ifid_instr_reg    <= NOP_INSTR;
            ifid_pc_reg       <= '0;
            ifid_pc_plus1_reg <= '0;
            ifid_valid_reg    <= 1'b0;
            fetch_cnt_reg     <= '0;
            flush_cnt_reg     <= '0;
        end else begin
            case (state_reg)
                FETCH_BOOT: begin
                    // pc holds; control inputs are not yet meaningful
                    state_reg      <= FETCH_RUN;
                    ifid_instr_reg <= NOP_INSTR;
                    ifid_valid_reg <= 1'b0;
                end
                FETCH_RUN: begin
                    if (stall) begin
                        // everything holds; ID re-presents kill next cycle
                    end else if (kill) begin
                        // the word at pc is on the wrong path: drop it
                        pc_reg         <= pc_target;
                        ifid_instr_reg <= NOP_INSTR;
                        ifid_valid_reg <= 1'b0;
                        if (flush_cnt_reg != '1)
                            flush_cnt_reg <= flush_cnt_reg + CNT_W'(1);
                    end else begin
                        pc_reg            <= pc_plus1;
                        ifid_instr_reg    <= imem_data;
                        ifid_pc_reg       <= pc_reg;
                        ifid_pc_plus1_reg <= pc_plus1;
                        ifid_valid_reg    <= 1'b1;
                        if (fetch_cnt_reg != '1)
                            fetch_cnt_reg <= fetch_cnt_reg + CNT_W'(1);
                    end
                end
                default: state_reg <= FETCH_BOOT;
            endcase
        end
    end

    // address comes straight from the register so stall/kill never reach imem
    assign imem_addr     = pc_reg;
    assign ifid_instr    = ifid_instr_reg;
    assign ifid_pc       = ifid_pc_reg;
    assign ifid_pc_plus1 = ifid_pc_plus1_reg;
    assign ifid_valid    = ifid_valid_reg;
    assign fetch_cnt     = fetch_cnt_reg;
    assign flush_cnt     = flush_cnt_reg;

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

    localparam int CNT_W = 3;   // small so saturation is reachable
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic        kill = 1'b0;
    logic [1:0]  pc_src = 2'd0;
    logic [15:0] jump_target = '0;
    logic [15:0] branch_target = '0;
    logic [15:0] ret_addr = '0;
    logic [15:0] imem_addr;
    logic [15:0] imem_data;
    logic [15:0] ifid_instr;
    logic [15:0] ifid_pc;
    logic [15:0] ifid_pc_plus1;
    logic        ifid_valid;
    logic [CNT_W-1:0] fetch_cnt;
    logic [CNT_W-1:0] flush_cnt;

    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    // instruction memory: imem[i] = 0x1000 + i
    assign imem_data = 16'h1000 + imem_addr;

    fetch_stage #(
        .PC_W(16), .INSTR_W(16), .RESET_PC(16'h0000),
        .NOP_INSTR(16'h0000), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset(reset), .stall(stall), .kill(kill), .pc_src(pc_src),
        .jump_target(jump_target), .branch_target(branch_target), .ret_addr(ret_addr),
        .imem_addr(imem_addr), .imem_data(imem_data), .ifid_instr(ifid_instr),
        .ifid_pc(ifid_pc), .ifid_pc_plus1(ifid_pc_plus1), .ifid_valid(ifid_valid),
        .fetch_cnt(fetch_cnt), .flush_cnt(flush_cnt)
    );

    typedef struct {
        logic        stall;
        logic        kill;
        logic [1:0]  src;
        logic [15:0] jt;
        logic [15:0] bt;
        logic [15:0] ra;
        logic [15:0] exp_pc;
        logic        exp_valid;
    } vec_t;

    typedef struct {
        logic [15:0] instr;
        logic [15:0] pc;
        logic [15:0] pc1;
    } fetch_t;

    fetch_t sb[$];

    // bench model state
    logic [15:0]      m_pc;
    logic             m_boot;
    logic             m_valid;
    logic [15:0]      m_instr;
    logic [15:0]      m_ifpc;
    logic [CNT_W-1:0] m_fetch;
    logic [CNT_W-1:0] m_flush;

    vec_t vecs[20];

    function automatic vec_t mk(input logic s, input logic k, input logic [1:0] src,
                                input logic [15:0] jt, input logic [15:0] bt,
                                input logic [15:0] ra, input logic [15:0] epc,
                                input logic ev);
        vec_t v;
        v.stall = s; v.kill = k; v.src = src; v.jt = jt; v.bt = bt; v.ra = ra;
        v.exp_pc = epc; v.exp_valid = ev;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    task automatic model_reset();
        m_pc = 16'h0000; m_boot = 1'b1; m_valid = 1'b0; m_instr = 16'h0000;
        m_ifpc = 16'h0000; m_fetch = '0; m_flush = '0;
        sb.delete();
    endtask

    task automatic step(input vec_t v, input string tag);
        logic   fetched;
        fetch_t e;
        fetched = 1'b0;
        stall = v.stall; kill = v.kill; pc_src = v.src;
        jump_target = v.jt; branch_target = v.bt; ret_addr = v.ra;
        if (m_boot) begin
            m_boot = 1'b0; m_valid = 1'b0; m_instr = 16'h0000;
        end else if (v.stall) begin
            // hold
        end else if (v.kill) begin
            case (v.src)
                2'd0: m_pc = m_pc + 16'd1;
                2'd1: m_pc = v.jt;
                2'd2: m_pc = v.bt;
                default: m_pc = v.ra;
            endcase
            m_valid = 1'b0; m_instr = 16'h0000;
            if (m_flush != CNT_MAX) m_flush = m_flush + 1'b1;
        end else begin
            e.instr = 16'h1000 + m_pc; e.pc = m_pc; e.pc1 = m_pc + 16'd1;
            sb.push_back(e);
            m_pc = m_pc + 16'd1;
            m_valid = 1'b1;
            if (m_fetch != CNT_MAX) m_fetch = m_fetch + 1'b1;
            fetched = 1'b1;
        end
        @(posedge clk);
        #1;
        $display("%s: s=%b k=%b src=%0d pc=%h valid=%b instr=%h ifpc=%h ifpc1=%h fcnt=%0d xcnt=%0d",
                 tag, v.stall, v.kill, v.src, imem_addr, ifid_valid, ifid_instr,
                 ifid_pc, ifid_pc_plus1, fetch_cnt, flush_cnt);
        check({tag, " pc(table)"}, 32'(imem_addr), 32'(v.exp_pc));
        check({tag, " valid(table)"}, 32'(ifid_valid), 32'(v.exp_valid));
        check({tag, " pc"}, 32'(imem_addr), 32'(m_pc));
        check({tag, " valid"}, 32'(ifid_valid), 32'(m_valid));
        check({tag, " fetch_cnt"}, 32'(fetch_cnt), 32'(m_fetch));
        check({tag, " flush_cnt"}, 32'(flush_cnt), 32'(m_flush));
        if (fetched) begin
            if (sb.size() == 0) begin
                check({tag, " scoreboard empty"}, 32'(1), 32'(0));
            end else begin
                e = sb.pop_front();
                check({tag, " ifid_instr"}, 32'(ifid_instr), 32'(e.instr));
                check({tag, " ifid_pc"}, 32'(ifid_pc), 32'(e.pc));
                check({tag, " ifid_pc_plus1"}, 32'(ifid_pc_plus1), 32'(e.pc1));
                m_instr = e.instr;
                m_ifpc = e.pc;
            end
        end else begin
            check({tag, " ifid_instr"}, 32'(ifid_instr), 32'(m_instr));
            if (m_valid)
                check({tag, " ifid_pc held"}, 32'(ifid_pc), 32'(m_ifpc));
        end
    endtask

    initial begin
        // S=stall K=kill
        vecs[0]  = mk(0, 0, 2'd0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0); // BOOT
        vecs[1]  = mk(0, 0, 2'd0, 16'h0000, 16'h0000, 16'h0000, 16'h0001, 1); // 1000 @0
        vecs[2]  = mk(0, 0, 2'd0, 16'h0000, 16'h0000, 16'h0000, 16'h0002, 1); // 1001 @1
        vecs[3]  = mk(0, 0, 2'd0, 16'h0000, 16'h0000, 16'h0000, 16'h0003, 1); // 1002 @2
        vecs[4]  = mk(0, 0, 2'd0, 16'h0000, 16'h0000, 16'h0000, 16'h0004, 1);
        vecs[5]  = mk(0, 0, 2'd0, 16'h0000, 16'h0000, 16'h0000, 16'h0005, 1);
        vecs[6]  = mk(0, 1, 2'd2, 16'h0000, 16'h0040, 16'h0000, 16'h0040, 0); // branch
        vecs[7]  = mk(0, 0, 2'd0, 16'h0000, 16'h0000, 16'h0000, 16'h0041, 1); // ifid_pc 40
        vecs[8]  = mk(0, 1, 2'd1, 16'h0008, 16'h0000, 16'h0000, 16'h0008, 0); // jump to 8
        vecs[9]  = mk(1, 0, 2'd0, 16'h0000, 16'h0000, 16'h0000, 16'h0008, 0); // stall x3
        vecs[10] = mk(1, 0, 2'd0, 16'h0000, 16'h0000, 16'h0000, 16'h0008, 0);
        vecs[11] = mk(1, 0, 2'd0, 16'h0000, 16'h0000, 16'h0000, 16'h0008, 0);
        vecs[12] = mk(0, 0, 2'd0, 16'h0000, 16'h0000, 16'h0000, 16'h0009, 1); // release
        vecs[13] = mk(1, 1, 2'd1, 16'h0020, 16'h0000, 16'h0000, 16'h0009, 1); // stall wins
        vecs[14] = mk(0, 1, 2'd1, 16'h0020, 16'h0000, 16'h0000, 16'h0020, 0);
        vecs[15] = mk(0, 1, 2'd1, 16'hFFFF, 16'h0000, 16'h0000, 16'hFFFF, 0);
        vecs[16] = mk(0, 0, 2'd0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1); // wrap
        vecs[17] = mk(0, 1, 2'd3, 16'h0000, 16'h0000, 16'h1234, 16'h1234, 0); // return
        vecs[18] = mk(0, 1, 2'd0, 16'h0000, 16'h0000, 16'h0000, 16'h1235, 0); // kill seq
        vecs[19] = mk(0, 0, 2'd0, 16'h0000, 16'h0000, 16'h0000, 16'h1236, 1);

        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset pc", 32'(imem_addr), 32'h0);
        check("reset valid", 32'(ifid_valid), 32'h0);
        check("reset instr", 32'(ifid_instr), 32'h0);
        check("reset fetch_cnt", 32'(fetch_cnt), 32'h0);
        reset = 1'b0;

        for (int i = 0; i < 20; i++)
            step(vecs[i], $sformatf("vec%0d", i));

        // fetch_cnt is pinned at its ceiling by now
        check("fetch_cnt saturated", 32'(fetch_cnt), 32'(CNT_MAX));

        // asynchronous reset in the middle of a kill cycle
        stall = 1'b0; kill = 1'b1; pc_src = 2'd2; branch_target = 16'h0077;
        #3 reset = 1'b1;
        #1;
        $display("async reset: pc=%h valid=%b instr=%h ifpc=%h ifpc1=%h fcnt=%0d xcnt=%0d",
                 imem_addr, ifid_valid, ifid_instr, ifid_pc, ifid_pc_plus1, fetch_cnt, flush_cnt);
        check("async pc", 32'(imem_addr), 32'h0);
        check("async valid", 32'(ifid_valid), 32'h0);
        check("async instr", 32'(ifid_instr), 32'h0);
        check("async ifid_pc", 32'(ifid_pc), 32'h0);
        check("async ifid_pc_plus1", 32'(ifid_pc_plus1), 32'h0);
        check("async fetch_cnt", 32'(fetch_cnt), 32'h0);
        check("async flush_cnt", 32'(flush_cnt), 32'h0);
        @(posedge clk);
        #1;
        check("reset held pc", 32'(imem_addr), 32'h0);
        reset = 1'b0;
        model_reset();
        step(mk(0, 1, 2'd2, 16'h0000, 16'h0077, 16'h0000, 16'h0000, 0), "reboot");
        step(mk(0, 0, 2'd0, 16'h0000, 16'h0000, 16'h0000, 16'h0001, 1), "refetch");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
